// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing.
// Used by uart_tx_drain today and by a future uart_rx fill block.
package uart_pkg;

    // PARITY is always part of the encoding so that both directions share one type.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // 100 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_baud_counter.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last count.
// Ports: clk, reset (sync, active high), clear (hold at 0), bit_done (1-cycle pulse).
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_done = (count == LAST) && !clear;

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops bytes from a show-ahead FIFO and sends them
// LSB-first, 8N1 (or 8E1 when UART_TX_PARITY_EN is defined).
// Ports: clk, reset (sync, active high), fifo_empty, fifo_dout[WIDTH] from FIFO;
//        fifo_deq (1-cycle pop strobe), tx (serial line, idle high), busy.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int WIDTH        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_deq,
    output logic             tx,
    output logic             busy
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

    uart_state_t      state;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_nxt;
    logic [IW-1:0]    bit_idx;
    logic             bit_done;
    logic             baud_clear;
`ifdef UART_TX_PARITY_EN
    logic             parity;
`endif

    // Pop in the same cycle the head byte is latched; reset suppresses it.
    assign fifo_deq   = (state == ST_IDLE) && !fifo_empty && !reset;
    // Holding the counter at 0 in IDLE restarts timing on every frame.
    assign baud_clear = (state == ST_IDLE);
    assign shift_nxt  = shift >> 1;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (baud_clear),
        .bit_done (bit_done)
    );

    // tx is loaded with the value of the next bit at each transition,
    // so the line always comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_deq) begin
                        shift   <= fifo_dout;
                        bit_idx <= '0;
                        state   <= ST_START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity  <= ^fifo_dout;
`endif
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        state <= ST_DATA;
                        tx    <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        shift <= shift_nxt;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= ST_PARITY;
                            tx      <= parity;
`else
                            state   <= ST_STOP;
                            tx      <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                            tx      <= shift_nxt[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done) begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain with CLKS_PER_BIT=4, a queue-based show-ahead FIFO,
// a per-cycle line model, a UART decoder, and directed scenarios.
module tb_uart_tx_drain;

    localparam int CPB = 4;
    localparam int W   = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = W + 3;
    localparam int GAP   = 45;
    localparam logic [NBITS-1:0] EXP_A5 = 11'b1_0_10100101_0;
    localparam logic [NBITS-1:0] EXP_07 = 11'b1_1_00000111_0;
    localparam logic [NBITS-1:0] EXP_03 = 11'b1_0_00000011_0;
`else
    localparam int NBITS = W + 2;
    localparam int GAP   = 41;
    localparam logic [NBITS-1:0] EXP_A5 = 10'b1_10100101_0;
`endif
    localparam int FRAME = NBITS * CPB;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_dout = '0;
    logic         fifo_deq;
    logic         tx;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_drain #(
        .CLKS_PER_BIT(CPB),
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_deq   (fifo_deq),
        .tx         (tx),
        .busy       (busy)
    );

    logic [W-1:0] fq[$];
    logic         enq = 1'b0;
    logic [W-1:0] enq_data = '0;
    logic         deq_s = 1'b0;
    logic         model_on = 1'b0;
    logic         exp_bits[$];

    int cyc = 0;
    int deq_count = 0;
    int busy_cycles = 0;

    logic             rx_on = 1'b0;
    logic             prev_tx = 1'b1;
    int               rx_start = 0;
    logic [NBITS-1:0] frame_bits = '0;
    logic [NBITS-1:0] last_frame = '0;
    logic [W-1:0]     rx_q[$];
    int               starts[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected line for one frame: start, LSB-first data, [parity], stop.
    task automatic build_frame(input logic [W-1:0] d);
        repeat (CPB) exp_bits.push_back(1'b0);
        for (int i = 0; i < W; i++)
            repeat (CPB) exp_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        repeat (CPB) exp_bits.push_back(^d);
`endif
        repeat (CPB) exp_bits.push_back(1'b1);
    endtask

    // Model step and FIFO update on each rising edge.
    always @(posedge clk) begin
        logic m_deq;
        model_on = 1'b1;
        m_deq = (exp_bits.size() == 0) && (fq.size() != 0) && !reset;
        if (reset)
            exp_bits.delete();
        else if (exp_bits.size() != 0)
            exp_bits.delete(0);
        else if (m_deq)
            build_frame(fq[0]);
        if (deq_s && fq.size() != 0)
            fq.delete(0);
        if (enq)
            fq.push_back(enq_data);
        #1;
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
    end

    // Per-cycle compare and line decoder, away from the active edge.
    always @(negedge clk) begin
        logic e_tx, e_busy, e_deq;
        int off;
        cyc++;
        if (model_on) begin
            e_busy = (exp_bits.size() != 0);
            e_tx   = e_busy ? exp_bits[0] : 1'b1;
            e_deq  = !e_busy && !fifo_empty && !reset;
            check("cyc_tx", 32'(tx), 32'(e_tx));
            check("cyc_busy", 32'(busy), 32'(e_busy));
            check("cyc_deq", 32'(fifo_deq), 32'(e_deq));
            deq_s = fifo_deq;
            if (fifo_deq === 1'b1) deq_count++;
            if (busy === 1'b1) busy_cycles++;
            if (reset) begin
                rx_on = 1'b0;
            end else if (!rx_on && prev_tx === 1'b1 && tx === 1'b0) begin
                rx_on    = 1'b1;
                rx_start = cyc;
                starts.push_back(cyc);
            end
            if (rx_on) begin
                off = cyc - rx_start;
                if (off % CPB == 2) frame_bits[off / CPB] = tx;
                if (off == FRAME - 2) begin
                    rx_on      = 1'b0;
                    last_frame = frame_bits;
                    rx_q.push_back(frame_bits[W:1]);
                end
            end
            prev_tx = tx;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        enq      = 1'b1;
        enq_data = d;
        tick();
        enq      = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        tick();
        while (!(busy === 1'b0 && fifo_empty && exp_bits.size() == 0 && !rx_on)
               && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL wait_idle actual timeout required idle within %0d", limit);
        end
    endtask

    initial begin
        int d0, b0, r0, s0, high_misses, n;

        tick(3);
        reset = 1'b0;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_deq", 32'(fifo_deq), 32'd0);
        high_misses = 0;
        repeat (100) begin
            tick();
            if (tx !== 1'b1) high_misses++;
        end
        check("idle_tx_high", 32'(high_misses), 32'd0);

        d0 = deq_count; b0 = busy_cycles; r0 = rx_q.size();
        push(8'hA5);
        wait_idle(200);
        check("a5_deq", 32'(deq_count - d0), 32'd1);
        check("a5_busy", 32'(busy_cycles - b0), 32'(FRAME));
        check("a5_nbytes", 32'(rx_q.size() - r0), 32'd1);
        check("a5_byte", 32'(rx_q[r0]), 32'hA5);
        check("a5_frame", 32'(last_frame), 32'(EXP_A5));
        check("a5_empty", 32'(fifo_empty), 32'd1);

        d0 = deq_count; r0 = rx_q.size(); s0 = starts.size();
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        wait_idle(600);
        check("b2b_deq", 32'(deq_count - d0), 32'd3);
        check("b2b_byte0", 32'(rx_q[r0]), 32'h00);
        check("b2b_byte1", 32'(rx_q[r0 + 1]), 32'hFF);
        check("b2b_byte2", 32'(rx_q[r0 + 2]), 32'h3C);
        check("b2b_gap01", 32'(starts[s0 + 1] - starts[s0]), 32'(GAP));
        check("b2b_gap12", 32'(starts[s0 + 2] - starts[s0 + 1]), 32'(GAP));

        d0 = deq_count; r0 = rx_q.size(); s0 = starts.size();
        push(8'h81);
        tick(12);
        push(8'h7E);
        tick(3);
        check("mid_one_deq", 32'(deq_count - d0), 32'd1);
        wait_idle(400);
        check("mid_deq", 32'(deq_count - d0), 32'd2);
        check("mid_byte0", 32'(rx_q[r0]), 32'h81);
        check("mid_byte1", 32'(rx_q[r0 + 1]), 32'h7E);
        check("mid_gap", 32'(starts[s0 + 1] - starts[s0]), 32'(GAP));

        d0 = deq_count;
        push(8'h55);
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("rm_started", 32'(busy), 32'd1);
        tick(17);
        check("rm_bit3", 32'(tx), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_tx", 32'(tx), 32'd1);
        check("rm_busy", 32'(busy), 32'd0);
        tick(60);
        check("rm_nodeq", 32'(deq_count - d0), 32'd1);
        r0 = rx_q.size();
        push(8'h12);
        wait_idle(200);
        check("rm_deq", 32'(deq_count - d0), 32'd2);
        check("rm_byte", 32'(rx_q[r0]), 32'h12);

`ifdef UART_TX_PARITY_EN
        b0 = busy_cycles;
        push(8'h07);
        wait_idle(200);
        check("par07_frame", 32'(last_frame), 32'(EXP_07));
        check("par07_busy", 32'(busy_cycles - b0), 32'd44);
        push(8'h03);
        wait_idle(200);
        check("par03_frame", 32'(last_frame), 32'(EXP_03));
`endif

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Serial transmitter that drains the byte FIFO and sends each byte over an 8N1 UART line. Sits on the read side of `FIFO`: it watches `empty`, pops the head byte with a one-cycle `deq` pulse, and serializes it LSB-first on `tx`. It is the consumer counterpart to whatever enqueues bytes into the FIFO, and provides the board's outbound debug/telemetry link.

## Interface
- `CLKS_PER_BIT`, default 868. Clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.
- `WIDTH`, default 8. Data bits per frame; must match the FIFO `WIDTH`.

Ports:
- `clk`  input  1  System clock. Single clock domain.
- `reset`  input  1  Synchronous, active-high reset.
- `fifo_empty`  input  1  FIFO `empty`. Head byte is valid on `fifo_dout` whenever this is low (show-ahead FIFO).
- `fifo_dout`  input  WIDTH  FIFO `dout`, the head byte.
- `fifo_deq`  output  1  One-cycle pop strobe to FIFO `deq`.
- `tx`  output  1  UART serial line. Idle high.
- `busy`  output  1  High while a frame is in progress.

## Operation
- States: IDLE, START, DATA, STOP, plus PARITY when `UART_TX_PARITY_EN` is defined.
- **IDLE:**
  - `tx`=1, `busy`=0.
  - In any cycle with `fifo_empty`=0: assert `fifo_deq` combinationally in that same cycle, latch `fifo_dout` into the shift register, clear the baud counter and go to START.
- **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- **DATA:**
  - `tx` = shift[0] for CLKS_PER_BIT cycles per bit.
  - Then shift right and increment the bit index.
  - After bit WIDTH-1, go to STOP, or to PARITY if enabled.
- **PARITY:** `tx` = XOR of the latched byte (even parity) for CLKS_PER_BIT cycles.
- **STOP:** `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- **Baud counter:**
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on a bit boundary.
  - Reset to 0 on every state entry from IDLE.
- **`fifo_deq` rules:**
  - Asserted only in IDLE with `fifo_empty`=0.
  - Never asserted when `fifo_empty`=1.
  - Never asserted for two consecutive cycles.
  - Exactly one pulse per frame.
- `fifo_dout` and `fifo_empty` are ignored outside IDLE. A byte enqueued mid-frame waits in the FIFO.
- **Reset:**
  - Takes effect on the next rising edge in any state.
  - FSM goes to IDLE and the in-flight byte is discarded (it was already popped).
  - `tx` returns high, which may produce a truncated frame on the line.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `fifo_deq`=0, state=IDLE, counter=0, bit index=0.
- **Latency:** `tx` falls on the clock edge after the `fifo_deq` cycle. `busy` rises on the same edge.
- **Frame length:** (WIDTH+2)·CLKS_PER_BIT cycles, or (WIDTH+3)·CLKS_PER_BIT with parity.
- **Back-to-back frames:**
  - After STOP the block spends exactly one cycle in IDLE before it can start again.
  - Start-bit edges are therefore spaced (WIDTH+2)·CLKS_PER_BIT+1 cycles apart while the FIFO stays non-empty.
- `busy` falls on the same edge that `tx` completes the stop bit and the FSM enters IDLE.
- **Simultaneous events:**
  - In the IDLE cycle, the FIFO write side may enqueue while the block pops. The pop consumes the old head; the FIFO owns that ordering.
  - `reset`=1 together with `fifo_empty`=0 in IDLE: reset wins and `fifo_deq`=0.
- `tx` is driven from a register, so the line never glitches.

## Configuration
- `UART_TX_PARITY_EN`, **defined:**
  - The PARITY state is compiled in.
  - The frame becomes 8E1: an even-parity bit of the latched byte is sent between the last data bit and the stop bit.
  - Frame length is (WIDTH+3)·CLKS_PER_BIT.
- `UART_TX_PARITY_EN`, **undefined:**
  - No parity state or parity logic exists.
  - The frame is 8N1, (WIDTH+2)·CLKS_PER_BIT.

## Structure
- **Shared package `uart_pkg`:** state encoding constants (IDLE, START, DATA, PARITY, STOP) and the default CLKS_PER_BIT. A future `uart_rx` fill block reuses these.
- **One sub-module, `uart_baud_counter`:**
  - Parameter CLKS_PER_BIT.
  - Inputs `clk`, `reset`, `clear`.
  - Output `bit_done`, a one-cycle pulse when the count reaches CLKS_PER_BIT-1.
  - The FSM, shift register and bit index stay in `uart_tx_drain`.

## Test plan
All scenarios use CLKS_PER_BIT=4 with the real `FIFO` instantiated.
- **Reset:** hold `reset` for 3 cycles with the FIFO empty → `tx`=1, `busy`=0, `fifo_deq`=0 throughout, and `tx` stays 1 for 100 cycles.
- **Single byte:** enqueue 0xA5 → exactly one `fifo_deq` pulse. Then `tx` = 0,1,0,1,0,0,1,0,1, then 1 (start, LSB-first data, stop), each held 4 cycles; 40 cycles total. `busy` is high for exactly 40 cycles and `empty` returns 1.
- **Back-to-back:** enqueue 0x00, 0xFF, 0x3C in consecutive cycles → three frames whose start edges are 41 cycles apart. A UART monitor decodes 0x00, 0xFF, 0x3C in order, and there are exactly 3 `fifo_deq` pulses.
- **Mid-frame enqueue:** enqueue 0x81, then enqueue 0x7E during 0x81's data bits → no `fifo_deq` until 0x81's stop bit completes. 0x7E is then sent 1 cycle after IDLE entry.
- **Reset mid-frame:** enqueue 0x55 and assert `reset` during data bit 3 → `tx`=1 on the next edge, `busy`=0, and no further `fifo_deq`. A subsequent enqueue of 0x12 transmits correctly.
- **Parity (`UART_TX_PARITY_EN` defined):** send 0x07 → parity bit 1, 44-cycle frame. Send 0x03 → parity bit 0.
